// File: rtl/watch_pkg.sv
// Shared constants for the watch time-setting path: key codes, digit positions,
// set-mode FSM states and the per-position BCD digit limits.
package watch_pkg;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    localparam logic [2:0] POS_HT = 3'd0;
    localparam logic [2:0] POS_HO = 3'd1;
    localparam logic [2:0] POS_MT = 3'd2;
    localparam logic [2:0] POS_MO = 3'd3;
    localparam logic [2:0] POS_ST = 3'd4;
    localparam logic [2:0] POS_SO = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        ENTRY,
        COMMIT,
        WAIT_REL
    } set_state_e;

    // Largest digit allowed at a position; hour ones depends on hour tens.
    function automatic logic [3:0] digit_max(input logic [2:0] pos, input logic [3:0] hour_tens);
        case (pos)
            POS_HT:         return 4'd2;
            POS_HO:         return (hour_tens == 4'd2) ? 4'd3 : 4'd9;
            POS_MT, POS_ST: return 4'd5;
            POS_MO, POS_SO: return 4'd9;
            default:        return 4'd9;
        endcase
    endfunction

    // Bit offset of a digit nibble in HHMMSS; position 0 is the top nibble.
    function automatic logic [4:0] nib_lsb(input logic [2:0] pos);
        return 5'd20 - {pos, 2'b00};
    endfunction

endpackage

// File: rtl/blink_gen.sv
// Free-running blink phase generator: phase toggles every HALF cycles,
// clr restarts the count in the "shown" phase (phase = 0).
module blink_gen #(
    parameter int unsigned HALF = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic phase
);

    localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt_q;
    logic          phase_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Keypad time-set sequencer: captures the running time, walks a cursor over six
// BCD digits with range checks, blinks the active digit and strobes a counter load.
module time_set_ctrl
    import watch_pkg::*;
#(
    parameter int unsigned BLINK_HALF  = 250,
    parameter int unsigned TIMEOUT_CYC = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_mode,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic [23:0] cur_time,
    output logic [23:0] edit_time,
    output logic [23:0] load_time,
    output logic        load_pulse,
    output logic        busy,
    output logic [2:0]  cursor,
    output logic [5:0]  blink_mask,
    output logic        err_pulse
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    set_state_e    state_q, state_d;
    logic          set_mode_q;
    logic [23:0]   edit_q, edit_d;
    logic [23:0]   load_q, load_d;
    logic [2:0]    cursor_q, cursor_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          blink_clr;
    logic          blink_phase;
    logic          set_rise;
    logic          key_live;

    assign set_rise = set_mode & ~set_mode_q;
    // Codes 12-15 are dead keys: no effect and no timeout/blink restart.
    assign key_live = key_valid & (key_code <= KEY_HASH);

    blink_gen #(
        .HALF(BLINK_HALF)
    ) u_blink (
        .clk  (clk),
        .rst  (rst),
        .clr  (blink_clr),
        .phase(blink_phase)
    );

    always_comb begin
        state_d    = state_q;
        edit_d     = edit_q;
        load_d     = load_q;
        cursor_d   = cursor_q;
        tmo_d      = tmo_q;
        err_d      = 1'b0;
        blink_clr  = 1'b0;
        busy       = 1'b0;
        load_pulse = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (set_rise) state_d = CAPTURE;
            end
            CAPTURE: begin
                busy      = 1'b1;
                edit_d    = cur_time;
                cursor_d  = POS_HT;
                tmo_d     = '0;
                blink_clr = 1'b1;
                state_d   = ENTRY;
            end
            ENTRY: begin
                busy = 1'b1;
                if (!set_mode) begin
                    state_d = IDLE;
                end else if (key_live) begin
                    tmo_d     = '0;
                    blink_clr = 1'b1;
                    if (key_code == KEY_HASH) begin
                        load_d  = edit_q;
                        state_d = COMMIT;
                    end else if (key_code == KEY_STAR) begin
                        if (cursor_q != POS_HT) cursor_d = cursor_q - 3'd1;
                    end else if (key_code <= digit_max(cursor_q, edit_q[23:20])) begin
                        edit_d[nib_lsb(cursor_q) +: 4] = key_code;
                        // Keep the hour legal when tens becomes 2 over a large ones digit.
                        if (cursor_q == POS_HT && key_code == 4'd2 && edit_q[19:16] > 4'd3) begin
                            edit_d[19:16] = 4'd0;
                        end
                        if (cursor_q != POS_SO) cursor_d = cursor_q + 3'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = WAIT_REL;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            COMMIT: begin
                busy       = 1'b1;
                load_pulse = 1'b1;
                state_d    = WAIT_REL;
            end
            WAIT_REL: begin
                if (!set_mode) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            set_mode_q <= 1'b0;
            edit_q     <= '0;
            load_q     <= '0;
            cursor_q   <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            set_mode_q <= set_mode;
            edit_q     <= edit_d;
            load_q     <= load_d;
            cursor_q   <= cursor_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
        end
    end

    assign edit_time  = edit_q;
    assign load_time  = load_q;
    assign cursor     = cursor_q;
    assign err_pulse  = err_q;
    assign blink_mask = (state_q == ENTRY && blink_phase) ? (6'b100000 >> cursor_q) : 6'b000000;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: a digit-array reference model predicts levels
// each cycle and queues expected load/err strobes for an independent monitor.
module tb_time_set_ctrl;

    localparam int unsigned BLINK_HALF  = 250;
    localparam int unsigned TIMEOUT_CYC = 10000;

    localparam int M_IDLE    = 0;
    localparam int M_CAPTURE = 1;
    localparam int M_ENTRY   = 2;
    localparam int M_COMMIT  = 3;
    localparam int M_WAIT    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        set_mode;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [23:0] cur_time;
    logic [23:0] edit_time;
    logic [23:0] load_time;
    logic        load_pulse;
    logic        busy;
    logic [2:0]  cursor;
    logic [5:0]  blink_mask;
    logic        err_pulse;

    always #5 clk = ~clk;

    time_set_ctrl #(
        .BLINK_HALF (BLINK_HALF),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .set_mode  (set_mode),
        .key_valid (key_valid),
        .key_code  (key_code),
        .cur_time  (cur_time),
        .edit_time (edit_time),
        .load_time (load_time),
        .load_pulse(load_pulse),
        .busy      (busy),
        .cursor    (cursor),
        .blink_mask(blink_mask),
        .err_pulse (err_pulse)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_load;
        logic [23:0] val;
        int          at;
    } ev_t;

    ev_t exp_q[$];

    // Reference model state.
    int          m_mode;
    int          m_dig[6];
    int          m_cur;
    logic [23:0] m_load;
    int          m_idle;
    int          m_age;
    bit          m_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [23:0] pack_digits();
        logic [23:0] v = '0;
        for (int i = 0; i < 6; i++) v = {v[19:0], 4'(m_dig[i])};
        return v;
    endfunction

    function automatic int digit_limit(input int p);
        case (p)
            0:       return 2;
            1:       return (m_dig[0] == 2) ? 3 : 9;
            2, 4:    return 5;
            default: return 9;
        endcase
    endfunction

    function automatic logic [5:0] exp_mask();
        logic [5:0] top = 6'b100000;
        if (m_mode == M_ENTRY && ((m_age / BLINK_HALF) % 2) == 1) return top >> m_cur;
        return 6'b000000;
    endfunction

    task automatic push_ev(input bit is_load, input logic [23:0] val);
        ev_t e;
        e.is_load = is_load;
        e.val     = val;
        e.at      = cyc + 1;
        exp_q.push_back(e);
    endtask

    // One clock of the reference model using the inputs about to be sampled.
    task automatic model_step();
        bit rise;
        if (rst) begin
            m_mode = M_IDLE;
            for (int i = 0; i < 6; i++) m_dig[i] = 0;
            m_cur  = 0;
            m_load = '0;
            m_idle = 0;
            m_age  = 0;
            m_prev = 1'b0;
            return;
        end
        rise   = set_mode && !m_prev;
        m_prev = set_mode;
        m_age++;
        case (m_mode)
            M_IDLE: if (rise) m_mode = M_CAPTURE;
            M_CAPTURE: begin
                for (int i = 0; i < 6; i++) m_dig[i] = int'(cur_time[20-4*i +: 4]);
                m_cur  = 0;
                m_idle = 0;
                m_age  = 0;
                m_mode = M_ENTRY;
            end
            M_ENTRY: begin
                if (!set_mode) begin
                    m_mode = M_IDLE;
                end else if (key_valid && key_code <= 4'd11) begin
                    m_idle = 0;
                    m_age  = 0;
                    if (key_code == 4'd11) begin
                        m_load = pack_digits();
                        push_ev(1'b1, m_load);
                        m_mode = M_COMMIT;
                    end else if (key_code == 4'd10) begin
                        m_cur = (m_cur > 0) ? m_cur - 1 : 0;
                    end else if (int'(key_code) <= digit_limit(m_cur)) begin
                        if (m_cur == 0 && key_code == 4'd2 && m_dig[1] > 3) m_dig[1] = 0;
                        m_dig[m_cur] = int'(key_code);
                        m_cur = (m_cur < 5) ? m_cur + 1 : 5;
                    end else begin
                        push_ev(1'b0, '0);
                    end
                end else if (m_idle == TIMEOUT_CYC - 1) begin
                    push_ev(1'b0, '0);
                    m_mode = M_WAIT;
                end else begin
                    m_idle++;
                end
            end
            M_COMMIT: m_mode = M_WAIT;
            default:  if (!set_mode) m_mode = M_IDLE;
        endcase
    endtask

    task automatic check_levels();
        chk("edit_time", 32'(edit_time), 32'(pack_digits()));
        chk("cursor", 32'(cursor), 32'(m_cur));
        chk("busy", 32'(busy),
            32'(m_mode == M_CAPTURE || m_mode == M_ENTRY || m_mode == M_COMMIT));
        chk("blink_mask", 32'(blink_mask), 32'(exp_mask()));
        chk("load_time", 32'(load_time), 32'(m_load));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_levels();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input logic [3:0] c, input int gap);
        key_valid = 1'b1;
        key_code  = c;
        tick();
        key_valid = 1'b0;
        idle(gap);
    endtask

    // Strobe monitor: every pulse must match the oldest queued expectation in time and kind.
    always @(negedge clk) begin
        if (load_pulse === 1'b1 || err_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse @cyc %0d: got load=%0b err=%0b expected none",
                         cyc, load_pulse, err_pulse);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(e.at));
                chk("pulse_kind", 32'({load_pulse, err_pulse}), 32'({e.is_load, !e.is_load}));
                if (e.is_load) chk("pulse_load_time", 32'(load_time), 32'(e.val));
            end
        end else if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            checks++;
            failures++;
            $display("FAIL missing_pulse @cyc %0d: got none expected %s due at %0d",
                     cyc, exp_q[0].is_load ? "load" : "err", exp_q[0].at);
            void'(exp_q.pop_front());
        end
    end

    initial begin
        int r;
        rst       = 1'b1;
        set_mode  = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'd0;
        cur_time  = '0;
        @(negedge clk);
        #1;
        idle(2);
        rst = 1'b0;
        idle(2);

        // Full entry 12:34:56 -> 23:59:59 and confirm.
        cur_time = 24'h123456;
        set_mode = 1'b1;
        idle(3);
        cur_time = 24'h000000;
        press(4'd2, 1); press(4'd3, 0); press(4'd5, 2); press(4'd9, 1);
        press(4'd5, 0); press(4'd9, 1); press(4'd11, 3);
        set_mode = 1'b0;
        idle(2);

        // Range checks and hour-ones fixup.
        cur_time = 24'h071530;
        set_mode = 1'b1;
        idle(3);
        press(4'd3, 1); press(4'd2, 1); press(4'd4, 1); press(4'd3, 1);
        press(4'd6, 0); press(4'd5, 1);
        set_mode = 1'b0;
        idle(2);

        // Backspace and cursor saturation at both ends.
        cur_time = 24'h100000;
        set_mode = 1'b1;
        idle(3);
        press(4'd1, 0); press(4'd4, 0); press(4'd10, 0); press(4'd5, 0);
        press(4'd10, 0); press(4'd10, 0); press(4'd10, 1);
        for (int i = 0; i < 8; i++) press(4'(i % 10), 0);
        press(4'd7, 0); press(4'd10, 1);
        set_mode = 1'b0;
        idle(2);

        // Timeout: dead keys must not restart it.
        set_mode = 1'b1;
        idle(3);
        press(4'd1, 100);
        press(4'd13, 50);
        press(4'd15, 0);
        idle(TIMEOUT_CYC - 140);
        set_mode = 1'b0;
        idle(3);

        // Abort coincident with '#', then reset mid-entry.
        set_mode = 1'b1;
        idle(3);
        press(4'd1, 1);
        set_mode  = 1'b0;
        key_valid = 1'b1;
        key_code  = 4'd11;
        tick();
        key_valid = 1'b0;
        idle(2);
        set_mode = 1'b1;
        idle(3);
        press(4'd2, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(4);
        set_mode = 1'b0;
        idle(2);

        // Blink on minute tens, restarted by a key in the hidden half.
        cur_time = 24'h000000;
        set_mode = 1'b1;
        idle(2);
        press(4'd1, 0); press(4'd2, 600);
        press(4'd3, 300);
        press(4'd12, 260);
        set_mode = 1'b0;
        idle(2);

        // Randomized sessions.
        for (int s = 0; s < 40; s++) begin
            set_mode = 1'b1;
            for (int j = 0; j < 60; j++) begin
                cur_time  = 24'($urandom);
                key_valid = ($urandom_range(0, 2) == 0);
                r = $urandom_range(0, 99);
                if (r < 70)      key_code = 4'($urandom_range(0, 9));
                else if (r < 86) key_code = 4'd10;
                else if (r < 90) key_code = 4'd11;
                else             key_code = 4'($urandom_range(12, 15));
                if ($urandom_range(0, 99) < 2) set_mode = ~set_mode;
                rst = ($urandom_range(0, 199) == 0);
                tick();
                rst       = 1'b0;
                key_valid = 1'b0;
                if (j == 30 && $urandom_range(0, 3) == 0) idle($urandom_range(200, 700));
            end
            key_valid = 1'b0;
            set_mode  = 1'b0;
            idle($urandom_range(1, 3));
        end

        idle(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
